// File: rtl/axi_arbiter_2to1.sv
// Two-master round-robin arbiter in front of a single-beat AXI slave.
// Independent write/read FSMs, one transaction per path; muxes combinational, grants registered.
module axi_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [STRB_WIDTH-1:0] m0_wstrb,
  input  logic                  m0_wlast,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [STRB_WIDTH-1:0] m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // slave
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wlast,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;
  logic    wgrant_q, wgrant_d, wlast_grant_q, wlast_grant_d;
  logic    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic    rgrant_q, rgrant_d, rlast_grant_q, rlast_grant_d;

  logic g_awvalid, g_wvalid, g_wlast, g_bready, g_arvalid, g_rready;
  logic g_awready, g_wready, g_bvalid, g_arready, g_rvalid;

  assign g_awvalid = wgrant_q ? m1_awvalid : m0_awvalid;
  assign g_wvalid  = wgrant_q ? m1_wvalid  : m0_wvalid;
  assign g_wlast   = wgrant_q ? m1_wlast   : m0_wlast;
  assign g_bready  = wgrant_q ? m1_bready  : m0_bready;
  assign g_arvalid = rgrant_q ? m1_arvalid : m0_arvalid;
  assign g_rready  = rgrant_q ? m1_rready  : m0_rready;

  assign s_awaddr = wgrant_q ? m1_awaddr : m0_awaddr;
  assign s_wdata  = wgrant_q ? m1_wdata  : m0_wdata;
  assign s_wstrb  = wgrant_q ? m1_wstrb  : m0_wstrb;
  assign s_wlast  = g_wlast;
  assign s_araddr = rgrant_q ? m1_araddr : m0_araddr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q      <= W_IDLE;
      rstate_q      <= R_IDLE;
      wgrant_q      <= 1'b0;
      rgrant_q      <= 1'b0;
      wlast_grant_q <= 1'b1;
      rlast_grant_q <= 1'b1;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      wstate_q      <= wstate_d;
      rstate_q      <= rstate_d;
      wgrant_q      <= wgrant_d;
      rgrant_q      <= rgrant_d;
      wlast_grant_q <= wlast_grant_d;
      rlast_grant_q <= rlast_grant_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
    end
  end

  always_comb begin
    wstate_d      = wstate_q;
    wgrant_d      = wgrant_q;
    wlast_grant_d = wlast_grant_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    s_awvalid     = 1'b0;
    s_wvalid      = 1'b0;
    s_bready      = 1'b0;
    g_awready     = 1'b0;
    g_wready      = 1'b0;
    g_bvalid      = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        // Only AW requests; a tie goes to whoever did not win last time.
        if (m0_awvalid | m1_awvalid) begin
          wgrant_d = (m0_awvalid & m1_awvalid) ? ~wlast_grant_q : m1_awvalid;
          wstate_d = W_XFER;
        end
      end
      W_XFER: begin
        s_awvalid = g_awvalid & ~aw_done_q;
        s_wvalid  = g_wvalid & ~w_done_q;
        g_awready = s_awready & ~aw_done_q;
        g_wready  = s_wready & ~w_done_q;
        if (s_awvalid & s_awready)           aw_done_d = 1'b1;
        if (s_wvalid & s_wready & g_wlast)   w_done_d  = 1'b1;
        if (aw_done_d & w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        g_bvalid = s_bvalid;
        s_bready = g_bready;
        if (s_bvalid & g_bready) begin
          wlast_grant_d = wgrant_q;
          wstate_d      = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d      = rstate_q;
    rgrant_d      = rgrant_q;
    rlast_grant_d = rlast_grant_q;
    s_arvalid     = 1'b0;
    s_rready      = 1'b0;
    g_arready     = 1'b0;
    g_rvalid      = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          rgrant_d = (m0_arvalid & m1_arvalid) ? ~rlast_grant_q : m1_arvalid;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid = g_arvalid;
        g_arready = s_arready;
        if (g_arvalid & s_arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        g_rvalid = s_rvalid;
        s_rready = g_rready;
        if (s_rvalid & g_rready & s_rlast) begin
          rlast_grant_d = rgrant_q;
          rstate_d      = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign m0_awready = g_awready & ~wgrant_q;
  assign m1_awready = g_awready &  wgrant_q;
  assign m0_wready  = g_wready  & ~wgrant_q;
  assign m1_wready  = g_wready  &  wgrant_q;
  assign m0_bvalid  = g_bvalid  & ~wgrant_q;
  assign m1_bvalid  = g_bvalid  &  wgrant_q;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;

  assign m0_arready = g_arready & ~rgrant_q;
  assign m1_arready = g_arready &  rgrant_q;
  assign m0_rvalid  = g_rvalid  & ~rgrant_q;
  assign m1_rvalid  = g_rvalid  &  rgrant_q;
  // rlast is qualified like a valid so a stale slave rlast never reaches either master.
  assign m0_rlast   = s_rlast & (rstate_q == R_DATA) & ~rgrant_q;
  assign m1_rlast   = s_rlast & (rstate_q == R_DATA) &  rgrant_q;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Bench for axi_arbiter_2to1: behavioural single-beat slave, two driven masters,
// and a response scoreboard popped by an independent monitor.
module tb_axi_arbiter_2to1;

  logic aclk, aresetn;
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // master-side stimulus, index = master number
  logic [1:0]  awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [2:0]  awaddr [2];
  logic [2:0]  araddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  wire  [1:0]  awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic [31:0] rdata  [2];

  // slave side
  logic [2:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        wready_en;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_rvalid, s_rlast;
  logic [31:0] s_rdata;
  wire         s_awready = 1'b1;
  wire         s_arready = 1'b1;
  wire         s_wready  = wready_en;
  wire  [1:0]  s_rresp   = 2'b00;

  axi_arbiter_2to1 #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wlast(wlast[0]), .m0_wvalid(wvalid[0]),
    .m0_wready(wready[0]), .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]), .m0_rvalid(rvalid[0]),
    .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wlast(wlast[1]), .m1_wvalid(wvalid[1]),
    .m1_wready(wready[1]), .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]), .m1_rvalid(rvalid[1]),
    .m1_rready(rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

  // Behavioural single-beat slave; address 7 answers SLVERR.
  logic [31:0] mem [8];
  logic        aw_got, w_got;
  logic [2:0]  aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  wire         aw_hs = s_awvalid & s_awready;
  wire         w_hs  = s_wvalid & s_wready;
  wire  [2:0]  wa    = aw_hs ? s_awaddr : aw_a;
  wire  [31:0] wd    = w_hs ? s_wdata : w_d;
  wire  [3:0]  ws    = w_hs ? s_wstrb : w_s;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= 3'd0; w_d <= 32'h0; w_s <= 4'h0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= 32'h0;
    end else begin
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= s_awaddr; end
      if (w_hs)  begin w_got <= 1'b1; w_d <= s_wdata; w_s <= s_wstrb; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mem[wa][8*b +: 8] <= wd[8*b +: 8];
        s_bvalid <= 1'b1;
        s_bresp  <= (wa == 3'd7) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1; s_rlast <= 1'b1; s_rdata <= mem[s_araddr];
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0; s_rlast <= 1'b0;
      end
    end
  end

  wire [16:0] vr_all = {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                        awready, wready, bvalid, arready, rvalid, rlast};

  typedef struct { int m; logic [1:0] resp; } bexp_t;
  typedef struct { int m; logic [31:0] data; } rexp_t;
  bexp_t b_exp [$];
  rexp_t r_exp [$];
  int nchk = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ch: 0 = AW, 1 = W, 2 = AR. Waits for ready at negedge, then drops valid after the edge.
  task automatic wait_hs(input int m, input int ch);
    int   n = 0;
    logic rdy;
    do begin
      @(negedge aclk);
      rdy = (ch == 0) ? awready[m] : (ch == 1) ? wready[m] : arready[m];
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      nchk++; nfail++;
      $display("FAIL hs_timeout: m%0d channel %0d ready stayed 0 for 100 cycles, expected a handshake", m, ch);
    end
    @(posedge aclk); #1;
    case (ch)
      0:       awvalid[m] = 1'b0;
      1:       wvalid[m]  = 1'b0;
      default: arvalid[m] = 1'b0;
    endcase
  endtask

  task automatic mwrite(input int m, input logic [2:0] a, input logic [31:0] d);
    awaddr[m] = a; awvalid[m] = 1'b1;
    wdata[m] = d; wstrb[m] = 4'hF; wlast[m] = 1'b1; wvalid[m] = 1'b1;
    fork
      wait_hs(m, 0);
      wait_hs(m, 1);
    join
  endtask

  task automatic mread(input int m, input logic [2:0] a);
    araddr[m] = a; arvalid[m] = 1'b1;
    wait_hs(m, 2);
  endtask

  task automatic drain();
    int n = 0;
    while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 300) begin
      @(negedge aclk); n++;
    end
    if (b_exp.size() != 0 || r_exp.size() != 0) begin
      nchk++; nfail++;
      $display("FAIL drain: %0d B and %0d R responses outstanding, expected 0", b_exp.size(), r_exp.size());
      b_exp.delete(); r_exp.delete();
    end
    @(posedge aclk); #1;
  endtask

  // Monitor: every response handshake presented to a master must match the queue head.
  initial begin
    bexp_t be;
    rexp_t re;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        for (int m = 0; m < 2; m++) begin
          if (bvalid[m] && bready[m]) begin
            if (b_exp.size() == 0) begin
              nchk++; nfail++;
              $display("FAIL b_unexpected: m%0d got bvalid, expected no response", m);
            end else begin
              be = b_exp.pop_front();
              check("b_master", 64'(m), 64'(be.m));
              check("b_resp", {62'd0, bresp[m]}, {62'd0, be.resp});
            end
          end
          if (rvalid[m] && rready[m]) begin
            if (r_exp.size() == 0) begin
              nchk++; nfail++;
              $display("FAIL r_unexpected: m%0d got rvalid, expected no response", m);
            end else begin
              re = r_exp.pop_front();
              check("r_master", 64'(m), 64'(re.m));
              check("r_data", {32'd0, rdata[m]}, {32'd0, re.data});
              check("r_last", {63'd0, rlast[m]}, 64'd1);
              check("r_last_other", {63'd0, rlast[1-m]}, 64'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    awvalid = '0; wvalid = '0; wlast = '0; arvalid = '0;
    bready = 2'b11; rready = 2'b11; wready_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; araddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #2 check("reset_outs", 64'(vr_all), 64'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("idle_outs", 64'(vr_all), 64'd0);
    @(posedge aclk); #1;

    // Three back-to-back ties: m0 (reset tie-break), then m1, then m0, then m1 alone.
    b_exp.push_back('{0, 2'b00}); b_exp.push_back('{1, 2'b00});
    b_exp.push_back('{0, 2'b00}); b_exp.push_back('{1, 2'b00});
    fork
      begin mwrite(0, 3'd2, 32'h2222_0002); mwrite(0, 3'd4, 32'h4444_0004); end
      begin mwrite(1, 3'd1, 32'h1111_0001); mwrite(1, 3'd6, 32'h6666_0006); end
    join
    drain();
    check("mem1", {32'd0, mem[1]}, 64'h1111_0001);
    check("mem2", {32'd0, mem[2]}, 64'h2222_0002);
    check("mem4", {32'd0, mem[4]}, 64'h4444_0004);
    check("mem6", {32'd0, mem[6]}, 64'h6666_0006);

    // m0 alone: one cycle of arbitration, then combinational pass-through.
    b_exp.push_back('{0, 2'b00});
    awaddr[0] = 3'd3; awvalid[0] = 1'b1;
    wdata[0] = 32'hA5A5_0001; wstrb[0] = 4'hF; wlast[0] = 1'b1; wvalid[0] = 1'b1;
    @(negedge aclk);
    check("t1_awvalid_idle", {63'd0, s_awvalid}, 64'd0);
    @(negedge aclk);
    check("t1_awvalid_xfer", {63'd0, s_awvalid}, 64'd1);
    check("t1_awaddr", {61'd0, s_awaddr}, 64'd3);
    check("t1_wdata", {32'd0, s_wdata}, 64'hA5A5_0001);
    check("t1_m0_rdy", {62'd0, awready[0], wready[0]}, 64'd3);
    check("t1_m1_rdy", {62'd0, awready[1], wready[1]}, 64'd0);
    @(posedge aclk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge aclk);
    check("t1_m1_bvalid", {63'd0, bvalid[1]}, 64'd0);
    drain();
    check("mem3", {32'd0, mem[3]}, 64'hA5A5_0001);

    // m1 W two cycles ahead of AW; slave holds wready low so AW and W complete apart.
    wready_en = 1'b0;
    b_exp.push_back('{1, 2'b00});
    wdata[1] = 32'h0BAD_F00D; wstrb[1] = 4'hF; wlast[1] = 1'b1; wvalid[1] = 1'b1;
    @(negedge aclk);
    check("t3_w_only_s_wvalid", {63'd0, s_wvalid}, 64'd0);
    check("t3_w_only_wready", {63'd0, wready[1]}, 64'd0);
    @(posedge aclk); @(posedge aclk); #1;
    awaddr[1] = 3'd0; awvalid[1] = 1'b1;
    @(negedge aclk);
    check("t3_no_grant_yet", {62'd0, s_awvalid, s_wvalid}, 64'd0);
    @(negedge aclk);
    check("t3_xfer_valids", {62'd0, s_awvalid, s_wvalid}, 64'd3);
    check("t3_xfer_readies", {62'd0, awready[1], wready[1]}, 64'd2);
    @(posedge aclk); #1;
    awvalid[1] = 1'b0; wready_en = 1'b1;
    @(negedge aclk);
    check("t3_aw_done", {62'd0, s_awvalid, s_wvalid}, 64'd1);
    check("t3_no_b_yet", {63'd0, bvalid[1]}, 64'd0);
    @(posedge aclk); #1;
    wvalid[1] = 1'b0;
    drain();
    check("mem0", {32'd0, mem[0]}, 64'h0BAD_F00D);

    // Concurrent m0 write and m1 read of the location written in the tie test.
    b_exp.push_back('{0, 2'b00});
    r_exp.push_back('{1, 32'h2222_0002});
    fork
      mwrite(0, 3'd5, 32'h5555_0005);
      mread(1, 3'd2);
    join
    drain();
    check("mem5", {32'd0, mem[5]}, 64'h5555_0005);

    // m0 holds off B for 4 cycles (SLVERR at addr 7); m1 waits with awready low.
    bready[0] = 1'b0;
    b_exp.push_back('{0, 2'b10});
    mwrite(0, 3'd7, 32'h7777_0007);
    b_exp.push_back('{1, 2'b00});
    fork
      mwrite(1, 3'd3, 32'h3333_0003);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("t5_bvalid_held", {63'd0, bvalid[0]}, 64'd1);
      check("t5_m1_awready", {63'd0, awready[1]}, 64'd0);
    end
    @(posedge aclk); #1;
    bready[0] = 1'b1;
    drain();
    check("mem3_m1", {32'd0, mem[3]}, 64'h3333_0003);

    // Reset while m0 is stuck in W_XFER (wready low), then a tie must go to m0.
    wready_en = 1'b0;
    awaddr[0] = 3'd6; awvalid[0] = 1'b1;
    wdata[0] = 32'hDEAD_0006; wstrb[0] = 4'hF; wlast[0] = 1'b1; wvalid[0] = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("t6_in_xfer", {63'd0, s_wvalid}, 64'd1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    awvalid = '0; wvalid = '0;
    #1 check("t6_reset_outs", 64'(vr_all), 64'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1; wready_en = 1'b1;
    @(posedge aclk); #1;
    b_exp.push_back('{0, 2'b00}); b_exp.push_back('{1, 2'b00});
    fork
      mwrite(0, 3'd0, 32'hC0C0_0000);
      mwrite(1, 3'd1, 32'hC1C1_0001);
    join
    drain();
    check("t6_mem6_not_written", {32'd0, mem[6]}, 64'd0);
    check("b_queue_empty", 64'(b_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
